// File: rtl/lsu_rmw.sv
// Load/store unit with sub-word read-modify-write toward a word-wide data memory.
// Loads and word stores take one memory cycle; byte/halfword stores read, then merge and write.
module lsu_rmw #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic {IDLE, MERGE} state_t;

  state_t      state;
  logic [29:0] cap_waddr;
  logic [1:0]  cap_lane;
  logic        cap_half;
  logic [15:0] cap_wdata;
  logic [31:0] cap_word;

  logic        out_of_range;
  logic        req_fault;
  logic        idle_req;
  logic        is_load;
  logic        word_store;
  logic        sub_store;
  logic        in_merge;
  logic [31:0] merged;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  assign out_of_range = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);

  always_comb begin
    req_fault = 1'b0;
    case (req_size)
      2'b00:   req_fault = 1'b0;
      2'b01:   req_fault = req_addr[0];
      2'b10:   req_fault = |req_addr[1:0];
      default: req_fault = 1'b1;
    endcase
    if (out_of_range) req_fault = 1'b1;
  end

  // Reset gates every enable combinationally so it wins over a same-cycle request
  // and aborts a pending merge write.
  assign idle_req   = !reset && (state == IDLE) && req_valid && !req_fault;
  assign is_load    = idle_req && !req_write;
  assign word_store = idle_req && req_write && (req_size == 2'b10);
  assign sub_store  = idle_req && req_write && (req_size != 2'b10);
  assign in_merge   = !reset && (state == MERGE);

  always_comb begin
    merged = cap_word;
    if (cap_half) begin
      if (cap_lane[1]) merged[31:16] = cap_wdata;
      else             merged[15:0]  = cap_wdata;
    end else begin
      case (cap_lane)
        2'd0:    merged[7:0]   = cap_wdata[7:0];
        2'd1:    merged[15:8]  = cap_wdata[7:0];
        2'd2:    merged[23:16] = cap_wdata[7:0];
        default: merged[31:24] = cap_wdata[7:0];
      endcase
    end
  end

  assign mem_read       = is_load || sub_store;
  assign mem_write      = word_store || in_merge;
  assign stall          = sub_store;
  assign mem_address    = in_merge ? {cap_waddr, 2'b00} : {req_addr[31:2], 2'b00};
  assign mem_write_data = in_merge ? merged : req_wdata;

  always_comb begin
    case (req_addr[1:0])
      2'd0:    load_byte = mem_read_data[7:0];
      2'd1:    load_byte = mem_read_data[15:8];
      2'd2:    load_byte = mem_read_data[23:16];
      default: load_byte = mem_read_data[31:24];
    endcase
    load_half = req_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (req_size)
      2'b00:   load_data = {{24{req_signed & load_byte[7]}}, load_byte};
      2'b01:   load_data = {{16{req_signed & load_half[15]}}, load_half};
      default: load_data = mem_read_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      fault      <= 1'b0;
      cap_waddr  <= 30'h0;
      cap_lane   <= 2'b00;
      cap_half   <= 1'b0;
      cap_wdata  <= 16'h0;
      cap_word   <= 32'h0;
    end else begin
      resp_valid <= is_load;
      fault      <= (state == IDLE) && req_valid && req_fault;
      if (is_load) resp_rdata <= load_data;
      case (state)
        IDLE: begin
          if (sub_store) begin
            cap_waddr <= req_addr[31:2];
            cap_lane  <= req_addr[1:0];
            cap_half  <= req_size[0];
            cap_wdata <= req_wdata[15:0];
            cap_word  <= mem_read_data;
            state     <= MERGE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
